// File: rtl/amstrad_pri_pkg.sv
// Shared constants and FSM state type for the CPC Plus programmable raster interrupt.
package amstrad_pri_pkg;

    localparam logic [2:0] PRI_ADDR = 3'd0;
    localparam logic [2:0] IVR_ADDR = 3'd5;

    localparam logic [1:0] SRC_RASTER = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ACK
    } pri_state_e;

endpackage

// File: rtl/amstrad_pri_irq_sync_edge.sv
// One-register edge detector: delays the input a cycle and flags rising/falling transitions.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;

    always_ff @(posedge clk) begin
        if (reset) din_d <= 1'b0;
        else       din_d <= din;
    end

    assign rise = ~din_d & din;
    assign fall = din_d & ~din;

endmodule

// File: rtl/amstrad_pri_irq.sv
// CPC Plus raster interrupt: scanline counter, PRI compare, IRQ/ACK FSM and IM2 vector.
// Optional IVR register and vector drive enabled by defining PRI_VECTOR_EN.
module amstrad_pri_irq #(
    parameter int LINE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              plus_mode,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              reg_wr,
    input  logic [2:0]        reg_addr,
    input  logic [7:0]        reg_din,
    input  logic              m1,
    input  logic              iorq,
    output logic              pri_irq,
    output logic              ga_int_mask,
    output logic [7:0]        vec_out,
    output logic              vec_oe,
    output logic [LINE_W-1:0] line_cnt
);
    import amstrad_pri_pkg::*;

    logic hs_rise, hs_fall, vs_rise, vs_fall;
    logic unused_edges;

    sync_edge u_hs (.clk(clk), .reset(reset), .din(hsync_i), .rise(hs_rise), .fall(hs_fall));
    sync_edge u_vs (.clk(clk), .reset(reset), .din(vsync_i), .rise(vs_rise), .fall(vs_fall));

    assign unused_edges = hs_rise ^ vs_fall;

    logic [7:0]        pri, pri_nxt;
    logic              pri_wr, pri_clr;
    logic [LINE_W-1:0] cnt_inc;
    logic              match;

    assign pri_wr  = reg_wr && (reg_addr == PRI_ADDR);
    assign pri_clr = pri_wr && (reg_din == 8'd0);
    assign pri_nxt = pri_wr ? reg_din : pri;
    assign cnt_inc = line_cnt + 1'b1;

    // At saturation cnt_inc wraps to 0, which never equals a non-zero PRI.
    assign match = hs_fall && !vs_rise && plus_mode && (pri != 8'd0) &&
                   (cnt_inc == LINE_W'(pri));

    always_ff @(posedge clk) begin
        if (reset) begin
            pri         <= 8'd0;
            ga_int_mask <= 1'b0;
            line_cnt    <= '0;
        end else begin
            pri         <= pri_nxt;
            ga_int_mask <= (pri_nxt != 8'd0);
            if (vs_rise)
                line_cnt <= '0;
            else if (hs_fall && !(&line_cnt))
                line_cnt <= cnt_inc;
        end
    end

    pri_state_e state, state_nxt;
    logic       ack_now, ack_d, ack_rise, ack_fall;
    logic       match_lat, match_lat_nxt;

    assign ack_now  = m1 & iorq;
    assign ack_rise = ack_now & ~ack_d;
    assign ack_fall = ~ack_now & ack_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ack_d     <= 1'b0;
            match_lat <= 1'b0;
        end else begin
            state     <= state_nxt;
            ack_d     <= ack_now;
            match_lat <= match_lat_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        match_lat_nxt = 1'b0;
        case (state)
            IDLE:    if (match) state_nxt = PENDING;
            PENDING: begin
                if (pri_clr || !plus_mode) begin
                    state_nxt = IDLE;
                end else if (ack_rise) begin
                    // A match coinciding with the acknowledge is carried through ACK.
                    state_nxt     = ACK;
                    match_lat_nxt = match;
                end
            end
            ACK: begin
                match_lat_nxt = (match_lat | match) & ~pri_clr;
                if (ack_fall) begin
                    state_nxt     = match_lat_nxt ? PENDING : IDLE;
                    match_lat_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pri_irq = (state == PENDING) && plus_mode;

`ifdef PRI_VECTOR_EN
    logic [7:3] ivr;

    always_ff @(posedge clk) begin
        if (reset)
            ivr <= 5'd0;
        else if (reg_wr && (reg_addr == IVR_ADDR))
            ivr <= reg_din[7:3];
    end

    assign vec_oe  = (state == ACK);
    assign vec_out = vec_oe ? {ivr, SRC_RASTER, 1'b0} : 8'hFF;
`else
    assign vec_oe  = 1'b0;
    assign vec_out = 8'hFF;
`endif

endmodule

// File: tb/tb_amstrad_pri_irq.sv
// Directed bench for amstrad_pri_irq: per-cycle vector table plus multi-cycle sequences.
module tb_amstrad_pri_irq;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       reset, plus_mode, hsync_i, vsync_i, reg_wr, m1, iorq;
    logic [2:0] reg_addr;
    logic [7:0] reg_din;
    logic       pri_irq, ga_int_mask, vec_oe;
    logic [7:0] vec_out, line_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    amstrad_pri_irq #(.LINE_W(8)) dut (
        .clk(clk), .reset(reset), .plus_mode(plus_mode),
        .hsync_i(hsync_i), .vsync_i(vsync_i),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_din(reg_din),
        .m1(m1), .iorq(iorq),
        .pri_irq(pri_irq), .ga_int_mask(ga_int_mask),
        .vec_out(vec_out), .vec_oe(vec_oe), .line_cnt(line_cnt)
    );

    typedef struct {
        logic       rst, pm, hs, vs, wr;
        logic [2:0] addr;
        logic [7:0] din;
        logic       ak;
        logic       e_irq, e_mask;
        logic [7:0] e_cnt;
        logic       e_ack;
    } vec_t;

    vec_t tbl [18];

    task automatic drv(input logic r, input logic pm, input logic hs, input logic vs,
                       input logic wr, input logic [2:0] a, input logic [7:0] d,
                       input logic ak);
        reset = r; plus_mode = pm; hsync_i = hs; vsync_i = vs;
        reg_wr = wr; reg_addr = a; reg_din = d; m1 = ak; iorq = ak;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e_irq, input logic e_mask,
                             input logic [7:0] e_cnt, input logic e_ack);
        logic       e_oe;
        logic [7:0] e_vec;
`ifdef PRI_VECTOR_EN
        e_oe  = e_ack;
        e_vec = e_ack ? 8'hA6 : 8'hFF;
`else
        e_oe  = 1'b0;
        e_vec = 8'hFF;
`endif
        chk($sformatf("%s.pri_irq", tag),     32'(pri_irq),     32'(e_irq));
        chk($sformatf("%s.ga_int_mask", tag), 32'(ga_int_mask), 32'(e_mask));
        chk($sformatf("%s.line_cnt", tag),    32'(line_cnt),    32'(e_cnt));
        chk($sformatf("%s.vec_oe", tag),      32'(vec_oe),      32'(e_oe));
        chk($sformatf("%s.vec_out", tag),     32'(vec_out),     32'(e_vec));
    endtask

    initial begin
        int  rises;
        logic prev_irq;

        //        rst pm hs vs wr addr  din    ak   irq mask cnt   ack
        tbl = '{
            '{H, H, L, L, L, 3'd0, 8'h00, L,  L, L, 8'd0, L},  // reset
            '{L, H, L, L, H, 3'd0, 8'h02, L,  L, H, 8'd0, L},  // PRI = 2
            '{L, H, L, L, H, 3'd5, 8'hA0, L,  L, H, 8'd0, L},  // IVR = A0
            '{L, H, L, H, L, 3'd0, 8'h00, L,  L, H, 8'd0, L},  // vsync rise
            '{L, H, H, L, L, 3'd0, 8'h00, L,  L, H, 8'd0, L},
            '{L, H, L, L, L, 3'd0, 8'h00, L,  L, H, 8'd1, L},  // line 1
            '{L, H, H, L, L, 3'd0, 8'h00, L,  L, H, 8'd1, L},
            '{L, H, L, L, L, 3'd0, 8'h00, L,  H, H, 8'd2, L},  // line 2 = PRI
            '{L, H, L, L, L, 3'd0, 8'h00, H,  L, H, 8'd2, H},  // acknowledge
            '{L, H, L, L, L, 3'd0, 8'h00, H,  L, H, 8'd2, H},
            '{L, H, L, L, L, 3'd0, 8'h00, L,  L, H, 8'd2, L},  // ack ends
            '{L, H, H, L, H, 3'd0, 8'h01, L,  L, H, 8'd2, L},  // PRI = 1
            '{L, H, L, H, L, 3'd0, 8'h00, L,  L, H, 8'd0, L},  // vs rise + hs fall
            '{L, H, H, H, L, 3'd0, 8'h00, L,  L, H, 8'd0, L},
            '{L, H, L, L, L, 3'd0, 8'h00, L,  H, H, 8'd1, L},  // line 1 = PRI
            '{L, H, L, L, H, 3'd0, 8'h00, L,  L, L, 8'd1, L},  // PRI = 0 clears
            '{L, L, H, L, H, 3'd0, 8'h02, L,  L, H, 8'd1, L},  // plus_mode off
            '{L, L, L, L, L, 3'd0, 8'h00, L,  L, H, 8'd2, L}   // match ignored
        };

        for (int i = 0; i < 18; i++) begin
            drv(tbl[i].rst, tbl[i].pm, tbl[i].hs, tbl[i].vs, tbl[i].wr,
                tbl[i].addr, tbl[i].din, tbl[i].ak);
            tick();
            check_out($sformatf("row%0d", i), tbl[i].e_irq, tbl[i].e_mask,
                      tbl[i].e_cnt, tbl[i].e_ack);
        end

        // PRI = 10 over a frame of 12 lines, then a 3-cycle acknowledge
        drv(L, H, L, L, H, 3'd0, 8'd10, L); tick();
        drv(L, H, L, H, L, 3'd0, 8'd0, L);  tick();
        drv(L, H, L, L, L, 3'd0, 8'd0, L);  tick();
        for (int k = 1; k <= 12; k++) begin
            drv(L, H, H, L, L, 3'd0, 8'd0, L); tick();
            drv(L, H, L, L, L, 3'd0, 8'd0, L); tick();
            check_out($sformatf("pri10.line%0d", k), (k >= 10), H, 8'(k), L);
        end
        for (int k = 0; k < 3; k++) begin
            drv(L, H, L, L, L, 3'd0, 8'd0, H); tick();
            check_out($sformatf("pri10.ack%0d", k), L, H, 8'd12, H);
        end
        drv(L, H, L, L, L, 3'd0, 8'd0, L); tick();
        check_out("pri10.ack_end", L, H, 8'd12, L);
        tick();
        check_out("pri10.idle", L, H, 8'd12, L);

        // new match on the same edge as the acknowledge must re-raise after ACK
        drv(L, H, L, L, H, 3'd0, 8'd1, L); tick();
        drv(L, H, L, H, L, 3'd0, 8'd0, L); tick();
        drv(L, H, H, L, L, 3'd0, 8'd0, L); tick();
        drv(L, H, L, L, L, 3'd0, 8'd0, L); tick();
        check_out("dual.first", H, H, 8'd1, L);
        drv(L, H, L, H, L, 3'd0, 8'd0, L); tick();
        check_out("dual.vsync", H, H, 8'd0, L);
        drv(L, H, H, L, L, 3'd0, 8'd0, L); tick();
        drv(L, H, L, L, L, 3'd0, 8'd0, H); tick();
        check_out("dual.ack_match", L, H, 8'd1, H);
        drv(L, H, L, L, L, 3'd0, 8'd0, L); tick();
        check_out("dual.repend", H, H, 8'd1, L);
        drv(L, H, L, L, L, 3'd0, 8'd0, H); tick();
        check_out("dual.ack2", L, H, 8'd1, H);

        // reset while in ACK
        drv(H, H, L, L, L, 3'd0, 8'd0, H); tick();
        check_out("rst_in_ack", L, L, 8'd0, L);
        drv(L, H, L, L, L, 3'd0, 8'd0, L); tick();
        check_out("rst_after", L, L, 8'd0, L);

        // PRI = 255, 300 lines without vsync: saturate and fire exactly once
        drv(L, H, L, L, H, 3'd0, 8'd255, L); tick();
        drv(L, H, L, H, L, 3'd0, 8'd0, L);   tick();
        drv(L, H, L, L, L, 3'd0, 8'd0, L);   tick();
        rises    = 0;
        prev_irq = pri_irq;
        for (int k = 1; k <= 300; k++) begin
            drv(L, H, H, L, L, 3'd0, 8'd0, L); tick();
            if (pri_irq && !prev_irq) rises++;
            prev_irq = pri_irq;
            drv(L, H, L, L, L, 3'd0, 8'd0, L); tick();
            if (pri_irq && !prev_irq) rises++;
            prev_irq = pri_irq;
            if (k == 254) chk("sat.irq_at_254", 32'(pri_irq), 32'd0);
            if (k == 255) chk("sat.irq_at_255", 32'(pri_irq), 32'd1);
        end
        chk("sat.line_cnt", 32'(line_cnt), 32'd255);
        chk("sat.rises", 32'(rises), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
